// File: rtl/segment_walker_pkg.sv
// Shared types and defaults for the segment walker.
// State encodings and descriptor widths match the descriptor queue.
package segment_walker_pkg;

    localparam int SW_IDX_W  = 32;
    localparam int SW_ADDR_W = 32;
    localparam int SW_ERR_W  = 16;
    localparam int SW_STAT_W = 32;

    typedef enum logic [1:0] {
        WALK_IDLE = 2'd0,
        WALK_WALK = 2'd1,
        WALK_DONE = 2'd2,
        WALK_ERR  = 2'd3
    } walk_state_e;

endpackage

// File: rtl/segment_walker.sv
// Pops segment descriptors and issues one tagged read per index si..ei.
// Optional counters stat_segs/stat_smps are built only with `WALK_STATS_EN.
module segment_walker
    import segment_walker_pkg::*;
#(
    parameter int IDX_W  = SW_IDX_W,
    parameter int ADDR_W = SW_ADDR_W,
    parameter int ERR_W  = SW_ERR_W
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              en,
    input  logic              q_valid,
    input  logic [IDX_W-1:0]  q_si,
    input  logic [IDX_W-1:0]  q_ei,
    input  logic [IDX_W-1:0]  q_id,
    output logic              q_pop,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [IDX_W-1:0]  rd_id,
    output logic              rd_last,
    output logic              seg_done,
    output logic [IDX_W-1:0]  seg_done_id,
    output logic              busy,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [31:0]       stat_segs,
    output logic [31:0]       stat_smps
);

    walk_state_e      state_q;
    logic [IDX_W-1:0] cur_q;
    logic [IDX_W-1:0] end_q;
    logic [IDX_W-1:0] id_q;
    logic [ERR_W-1:0] err_q;
    logic [IDX_W-1:0] cur_d;
    logic             at_end;
    logic             hs;

    assign at_end = (cur_q == end_q);
    assign cur_d  = cur_q + IDX_W'(1);
    assign hs     = rd_valid && rd_ready;

    // Gated by Rst so no pop can escape while reset holds the FSM in IDLE.
    assign q_pop = Rst && (state_q == WALK_IDLE) && en && q_valid;

    assign rd_valid    = (state_q == WALK_WALK);
    assign rd_addr     = cur_q[ADDR_W-1:0];
    assign rd_id       = id_q;
    assign rd_last     = rd_valid && at_end;
    assign seg_done    = (state_q == WALK_DONE);
    assign seg_done_id = id_q;
    assign busy        = (state_q != WALK_IDLE);
    assign err_cnt     = err_q;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= WALK_IDLE;
            cur_q   <= '0;
            end_q   <= '0;
            id_q    <= '0;
            err_q   <= '0;
        end else begin
            unique case (state_q)
                WALK_IDLE: begin
                    if (en && q_valid) begin
                        cur_q   <= q_si;
                        end_q   <= q_ei;
                        id_q    <= q_id;
                        state_q <= (q_ei >= q_si) ? WALK_WALK : WALK_ERR;
                    end
                end
                WALK_WALK: begin
                    // Compare before increment: ei of all-ones never wraps.
                    if (rd_ready) begin
                        if (at_end) state_q <= WALK_DONE;
                        else        cur_q   <= cur_d;
                    end
                end
                WALK_DONE: state_q <= WALK_IDLE;
                WALK_ERR: begin
                    if (err_q != '1) err_q <= err_q + ERR_W'(1);
                    state_q <= WALK_IDLE;
                end
            endcase
        end
    end

`ifdef WALK_STATS_EN
    logic [31:0] segs_q;
    logic [31:0] smps_q;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            segs_q <= '0;
            smps_q <= '0;
        end else begin
            if (seg_done) segs_q <= segs_q + 32'd1;
            if (hs)       smps_q <= smps_q + 32'd1;
        end
    end

    assign stat_segs = segs_q;
    assign stat_smps = smps_q;
`else
    logic unused_hs;
    assign unused_hs = hs;
    assign stat_segs = '0;
    assign stat_smps = '0;
`endif

endmodule

// File: tb/tb_segment_walker.sv
// Directed self-checking bench for segment_walker.
// Covers walk, single index, error drop, stalls, en gating and async reset.
module tb_segment_walker;

    logic        Clk;
    logic        Rst;
    logic        en;
    logic        q_valid;
    logic [31:0] q_si;
    logic [31:0] q_ei;
    logic [31:0] q_id;
    logic        q_pop;
    logic        rd_valid;
    logic        rd_ready;
    logic [31:0] rd_addr;
    logic [31:0] rd_id;
    logic        rd_last;
    logic        seg_done;
    logic [31:0] seg_done_id;
    logic        busy;
    logic [15:0] err_cnt;
    logic [31:0] stat_segs;
    logic [31:0] stat_smps;

    int n_chk = 0;
    int n_bad = 0;

    segment_walker dut (
        .Clk(Clk), .Rst(Rst), .en(en), .q_valid(q_valid),
        .q_si(q_si), .q_ei(q_ei), .q_id(q_id), .q_pop(q_pop),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rd_id(rd_id), .rd_last(rd_last), .seg_done(seg_done),
        .seg_done_id(seg_done_id), .busy(busy), .err_cnt(err_cnt),
        .stat_segs(stat_segs), .stat_smps(stat_smps)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic put(input logic [31:0] si, input logic [31:0] ei,
                       input logic [31:0] id);
        q_si    = si;
        q_ei    = ei;
        q_id    = id;
        q_valid = 1'b1;
        #1;
    endtask

    logic [3:0] pat;
    int acc;
    int cyc;
    bit done;
    bit held;
    logic [31:0] held_addr;
    int pops;

    initial begin
        Rst = 1'b0; en = 1'b0; q_valid = 1'b0; rd_ready = 1'b0;
        q_si = '0; q_ei = '0; q_id = '0;
        #12;
        chk("rst_pop", 32'(q_pop), 32'd0);
        chk("rst_rdv", 32'(rd_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_addr", rd_addr, 32'd0);
        chk("rst_err", 32'(err_cnt), 32'd0);
        chk("rst_sdone", 32'(seg_done), 32'd0);
        Rst = 1'b1;
        tick();

        // 1: 10..13 id 7, head stays valid through the walk
        en = 1'b1; rd_ready = 1'b1;
        put(32'd10, 32'd13, 32'd7);
        chk("t1_pop", 32'(q_pop), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t1_rdv", 32'(rd_valid), 32'd1);
            chk("t1_addr", rd_addr, 32'd10 + 32'(i));
            chk("t1_id", rd_id, 32'd7);
            chk("t1_last", 32'(rd_last), (i == 3) ? 32'd1 : 32'd0);
            chk("t1_nopop", 32'(q_pop), 32'd0);
        end
        tick();
        q_valid = 1'b0;
        chk("t1_done", 32'(seg_done), 32'd1);
        chk("t1_did", seg_done_id, 32'd7);
        chk("t1_rdv0", 32'(rd_valid), 32'd0);
        chk("t1_dpop", 32'(q_pop), 32'd0);
        tick();
        chk("t1_idle", 32'(busy), 32'd0);
        chk("t1_done0", 32'(seg_done), 32'd0);

        // 2: single index
        put(32'd5, 32'd5, 32'd4);
        chk("t2_pop", 32'(q_pop), 32'd1);
        tick();
        q_valid = 1'b0;
        chk("t2_addr", rd_addr, 32'd5);
        chk("t2_last", 32'(rd_last), 32'd1);
        chk("t2_rdv", 32'(rd_valid), 32'd1);
        tick();
        chk("t2_done", 32'(seg_done), 32'd1);
        chk("t2_did", seg_done_id, 32'd4);
        tick();

        // 3: ei < si is dropped
        put(32'd20, 32'd3, 32'd8);
        chk("t3_pop", 32'(q_pop), 32'd1);
        tick();
        q_valid = 1'b0;
        chk("t3_rdv", 32'(rd_valid), 32'd0);
        chk("t3_busy", 32'(busy), 32'd1);
        chk("t3_err0", 32'(err_cnt), 32'd0);
        tick();
        chk("t3_err1", 32'(err_cnt), 32'd1);
        chk("t3_idle", 32'(busy), 32'd0);
        chk("t3_done", 32'(seg_done), 32'd0);

        // 4: 0..3 with rd_ready 1,0,0,1 repeating
        pat = 4'b1001;
        put(32'd0, 32'd3, 32'd11);
        tick();
        q_valid = 1'b0;
        acc = 0; cyc = 0; done = 1'b0; held = 1'b0;
        while (!done && cyc < 40) begin
            rd_ready = pat[cyc % 4];
            #1;
            if (seg_done) begin
                done = 1'b1;
                chk("t4_did", seg_done_id, 32'd11);
            end else if (rd_valid) begin
                if (held) chk("t4_hold", rd_addr, held_addr);
                if (rd_ready) begin
                    chk("t4_addr", rd_addr, 32'(acc));
                    chk("t4_last", 32'(rd_last), (acc == 3) ? 32'd1 : 32'd0);
                    acc++;
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    held_addr = rd_addr;
                end
            end
            cyc++;
            if (!done) tick();
        end
        chk("t4_acc", 32'(acc), 32'd4);
        chk("t4_fin", 32'(done), 32'd1);
        rd_ready = 1'b1;
        tick();

        // 5: en dropped during first walk holds off the second pop
        put(32'd30, 32'd32, 32'd1);
        chk("t5_popA", 32'(q_pop), 32'd1);
        tick();
        en = 1'b0;
        put(32'd40, 32'd41, 32'd2);
        pops = 0;
        for (int i = 0; i < 10; i++) begin
            if (q_pop) pops++;
            if (seg_done) chk("t5_didA", seg_done_id, 32'd1);
            tick();
        end
        chk("t5_nopop", 32'(pops), 32'd0);
        chk("t5_idle", 32'(busy), 32'd0);
        en = 1'b1;
        #1;
        chk("t5_popB", 32'(q_pop), 32'd1);
        tick();
        q_valid = 1'b0;
        chk("t5_addrB", rd_addr, 32'd40);
        chk("t5_idB", rd_id, 32'd2);
        tick();
        tick();
        chk("t5_doneB", 32'(seg_done), 32'd1);
        tick();

        // 6: async reset at cur=2 of 0..9
        put(32'd0, 32'd9, 32'd3);
        tick();
        tick();
        tick();
        chk("t6_cur2", rd_addr, 32'd2);
        #2;
        Rst = 1'b0;
        #1;
        chk("t6_rdv", 32'(rd_valid), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_addr", rd_addr, 32'd0);
        chk("t6_id", rd_id, 32'd0);
        chk("t6_pop", 32'(q_pop), 32'd0);
        chk("t6_err", 32'(err_cnt), 32'd0);
        tick();
        Rst = 1'b1;
        put(32'd50, 32'd50, 32'd9);
        chk("t6_pop2", 32'(q_pop), 32'd1);
        tick();
        q_valid = 1'b0;
        chk("t6_addr2", rd_addr, 32'd50);
        chk("t6_last2", 32'(rd_last), 32'd1);
        tick();
        chk("t6_done", 32'(seg_done), 32'd1);
        chk("t6_did", seg_done_id, 32'd9);
        tick();

`ifdef WALK_STATS_EN
        chk("st_segs", stat_segs, 32'd1);
        chk("st_smps", stat_smps, 32'd1);
`else
        chk("st_segs", stat_segs, 32'd0);
        chk("st_smps", stat_smps, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
